// File: rtl/pwm_fault_pkg.sv
// -----------------------------------------------------------------------------
// pwm_fault_pkg
// Shared definitions for the PWM fault/brake controller:
//   - DEF_CH / DEF_FILT_W : default channel count and fault filter width
//   - state_t             : controller state encoding, also reported to the
//                           status register (IDLE=0, ARMED=1, TRIPPED=2,
//                           RECOVER=3)
//   - is_forced()         : true in the states that override the pads
// -----------------------------------------------------------------------------
package pwm_fault_pkg;

  localparam int DEF_CH     = 12;
  localparam int DEF_FILT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Outputs stay forced through RECOVER so release happens only on prd_end.
  function automatic logic is_forced(input state_t s);
    return (s == TRIPPED) || (s == RECOVER);
  endfunction

endpackage

// File: rtl/pwm_fault_if.sv
// -----------------------------------------------------------------------------
// pwm_fault_if
// Register-file side of the fault controller: quasi-static configuration and
// the software clear pulse travel towards the controller, interrupt and status
// travel back.
//   master : APB register file (drives cfg_*, sw_clr; reads status)
//   slave  : pwm_fault_ctrl    (reads cfg_*, sw_clr; drives status)
// Signals:
//   cfg_en, cfg_pol, cfg_filt[FILT_W], cfg_auto, cfg_hiz, cfg_safe_lvl[CH],
//   sw_clr, fault_int, fault_sts, state[2]
// -----------------------------------------------------------------------------
interface pwm_fault_if
  import pwm_fault_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int FILT_W = DEF_FILT_W
);

  logic              cfg_en;
  logic              cfg_pol;
  logic [FILT_W-1:0] cfg_filt;
  logic              cfg_auto;
  logic              cfg_hiz;
  logic [CH-1:0]     cfg_safe_lvl;
  logic              sw_clr;
  logic              fault_int;
  logic              fault_sts;
  logic [1:0]        state;

  modport master (
    output cfg_en, cfg_pol, cfg_filt, cfg_auto, cfg_hiz, cfg_safe_lvl, sw_clr,
    input  fault_int, fault_sts, state
  );

  modport slave (
    input  cfg_en, cfg_pol, cfg_filt, cfg_auto, cfg_hiz, cfg_safe_lvl, sw_clr,
    output fault_int, fault_sts, state
  );

endinterface

// File: rtl/pwm_fault_filt.sv
// -----------------------------------------------------------------------------
// pwm_fault_filt
// Fault pin conditioning: polarity normalisation, 2-flop synchroniser and a
// saturating run-length counter.
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   fault         : raw asynchronous fault pin
//   cfg_pol       : active level of the pin (1 = active high)
//   cfg_filt      : consecutive active cycles needed to trip (0 acts as 1)
//   clr           : hold the counter at zero (controller in IDLE/TRIPPED)
//   flt_s         : synchronised "pin is active"
//   trip_det      : flt_s has been active for the programmed number of cycles
// -----------------------------------------------------------------------------
module pwm_fault_filt
  import pwm_fault_pkg::*;
#(
  parameter int FILT_W = DEF_FILT_W
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              fault,
  input  logic              cfg_pol,
  input  logic [FILT_W-1:0] cfg_filt,
  input  logic              clr,
  output logic              flt_s,
  output logic              trip_det
);

  logic              act_raw;
  logic              sync1_reg;
  logic              sync2_reg;
  logic [FILT_W-1:0] cnt_reg;
  logic [FILT_W-1:0] n_lim;
  logic [FILT_W:0]   cnt_p1;

  // High when the pin sits at its active level, whichever polarity is chosen,
  // so a reset synchroniser value of 0 always means "inactive".
  assign act_raw = ~(fault ^ cfg_pol);

  assign n_lim  = (cfg_filt == '0) ? FILT_W'(1) : cfg_filt;
  assign cnt_p1 = {1'b0, cnt_reg} + (FILT_W + 1)'(1);

  // cnt_reg counts the active cycles before the current one, so the current
  // cycle completes the run when cnt+1 reaches the limit.
  assign flt_s    = sync2_reg;
  assign trip_det = sync2_reg && (cnt_p1 >= {1'b0, n_lim});

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= act_raw;
      sync2_reg <= sync1_reg;
      if (clr || !sync2_reg) begin
        cnt_reg <= '0;
      end else if (cnt_p1 <= {1'b0, n_lim}) begin
        cnt_reg <= cnt_p1[FILT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pwm_fault_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_fault_ctrl
// Fault/brake controller sitting between the PWM channel generators and the
// pads. A filtered fault trips the controller, which forces every channel to
// its safe level (or Hi-Z), pulses an interrupt, and later releases the pads
// on a PWM period boundary after software or automatic recovery.
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   fault         : raw asynchronous fault pin
//   prd_end       : one-cycle PWM period-end pulse
//   pwm_in        : raw channel outputs
//   oe_n_in       : raw output enables (active-low)
//   o_pwm         : gated PWM outputs to pads
//   oe_n          : gated output enables (active-low)
//   bus           : register-file interface (configuration, sw_clr, status)
// -----------------------------------------------------------------------------
module pwm_fault_ctrl
  import pwm_fault_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int FILT_W = DEF_FILT_W
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          fault,
  input  logic          prd_end,
  input  logic [CH-1:0] pwm_in,
  input  logic [CH-1:0] oe_n_in,
  output logic [CH-1:0] o_pwm,
  output logic [CH-1:0] oe_n,
  pwm_fault_if.slave    bus
);

  state_t state_reg;
  logic   fault_int_reg;
  logic   fault_sts_reg;
  logic   flt_s;
  logic   trip_det;
  logic   filt_clr;
  logic   forced;

  // A fresh run is demanded after arming and after every trip.
  assign filt_clr = (state_reg == IDLE) || (state_reg == TRIPPED);

  pwm_fault_filt #(
    .FILT_W (FILT_W)
  ) u_filt (
    .pclk     (pclk),
    .presetn  (presetn),
    .fault    (fault),
    .cfg_pol  (bus.cfg_pol),
    .cfg_filt (bus.cfg_filt),
    .clr      (filt_clr),
    .flt_s    (flt_s),
    .trip_det (trip_det)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      fault_int_reg <= 1'b0;
      fault_sts_reg <= 1'b0;
    end else begin
      fault_int_reg <= 1'b0;
      if (!bus.cfg_en) begin
        state_reg     <= IDLE;
        fault_sts_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= ARMED;
          end
          ARMED: begin
            // Trip takes precedence over a coincident sw_clr: status stays set.
            if (trip_det) begin
              state_reg     <= TRIPPED;
              fault_int_reg <= 1'b1;
              fault_sts_reg <= 1'b1;
            end else if (bus.sw_clr) begin
              fault_sts_reg <= 1'b0;
            end
          end
          TRIPPED: begin
            // No recovery while the pin is still active, even on sw_clr.
            if (!flt_s && (bus.cfg_auto || bus.sw_clr)) begin
              state_reg <= RECOVER;
            end
          end
          RECOVER: begin
            if (trip_det) begin
              state_reg     <= TRIPPED;
              fault_int_reg <= 1'b1;
              fault_sts_reg <= 1'b1;
            end else begin
              if (prd_end) begin
                state_reg <= ARMED;
              end
              if (bus.sw_clr) begin
                fault_sts_reg <= 1'b0;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign forced = is_forced(state_reg);

  // Per-pad override straight from the registered state, so forcing and
  // release take effect in the same cycle the state changes.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_pad
      assign o_pwm[gi] = forced ? bus.cfg_safe_lvl[gi] : pwm_in[gi];
      assign oe_n[gi]  = forced ? bus.cfg_hiz          : oe_n_in[gi];
    end
  endgenerate

  assign bus.state     = state_reg;
  assign bus.fault_int = fault_int_reg;
  assign bus.fault_sts = fault_sts_reg;

endmodule

// File: tb/tb_pwm_fault_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_fault_ctrl
// Self-checking bench for pwm_fault_ctrl: filter/latency vector table, output
// forcing table, hand-written recovery/polarity/disable sequences, and a
// randomized run against a window-based reference model.
// -----------------------------------------------------------------------------
module tb_pwm_fault_ctrl;
  import pwm_fault_pkg::*;

  localparam int CH = 12;
  localparam int FW = 8;

  logic          pclk    = 1'b0;
  logic          presetn = 1'b0;
  logic          fault   = 1'b0;
  logic          prd_end = 1'b0;
  logic [CH-1:0] pwm_in  = '0;
  logic [CH-1:0] oe_n_in = '0;
  logic [CH-1:0] o_pwm;
  logic [CH-1:0] oe_n;

  pwm_fault_if #(.CH(CH), .FILT_W(FW)) bus ();

  pwm_fault_ctrl #(.CH(CH), .FILT_W(FW)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .fault   (fault),
    .prd_end (prd_end),
    .pwm_in  (pwm_in),
    .oe_n_in (oe_n_in),
    .o_pwm   (o_pwm),
    .oe_n    (oe_n),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_st(input string nm, input state_t exp);
    chk(nm, 32'(bus.state), 32'(exp));
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Configuration with the pin parked at its inactive level and the block disabled.
  task automatic init_cfg(input int filt, input bit pol, input bit a_en, input bit hiz,
                          input logic [CH-1:0] safe);
    bus.cfg_en       = 1'b0;
    bus.cfg_pol      = pol;
    bus.cfg_filt     = FW'(filt);
    bus.cfg_auto     = a_en;
    bus.cfg_hiz      = hiz;
    bus.cfg_safe_lvl = safe;
    bus.sw_clr       = 1'b0;
    prd_end          = 1'b0;
    fault            = ~pol;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    nclk(2);
    presetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Trip rule as a window check: the pin must be active now
  // and in each of the previous N-1 cycles during which the controller was
  // watching (ARMED or RECOVER). m_q models the two-sample synchroniser delay.
  // ---------------------------------------------------------------------------
  int m_state;
  bit m_int;
  bit m_sts;
  bit m_q[$];
  bit m_hist[$];

  task automatic m_reset();
    m_state = 0;
    m_int   = 1'b0;
    m_sts   = 1'b0;
    m_q     = '{1'b0, 1'b0};
    m_hist.delete();
    repeat (16) m_hist.push_back(1'b0);
  endtask

  task automatic m_step();
    int n;
    bit flt;
    bit trip;
    bit watching;
    n        = (bus.cfg_filt == '0) ? 1 : int'(bus.cfg_filt);
    flt      = m_q[1];
    watching = (m_state == 1) || (m_state == 3);
    trip     = flt;
    for (int i = 0; i < n - 1; i++) trip = trip && m_hist[i];
    m_int = 1'b0;
    if (!bus.cfg_en) begin
      m_state = 0;
      m_sts   = 1'b0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (trip) begin
            m_state = 2; m_int = 1'b1; m_sts = 1'b1;
          end else if (bus.sw_clr) m_sts = 1'b0;
        end
        2: if (!flt && (bus.cfg_auto || bus.sw_clr)) m_state = 3;
        default: begin
          if (trip) begin
            m_state = 2; m_int = 1'b1; m_sts = 1'b1;
          end else begin
            if (prd_end) m_state = 1;
            if (bus.sw_clr) m_sts = 1'b0;
          end
        end
      endcase
    end
    m_hist.push_front(flt && watching);
    void'(m_hist.pop_back());
    m_q.push_front(fault == bus.cfg_pol);
    void'(m_q.pop_back());
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    int filt;
    bit pol;
    int pulse;  // cycles the pin is held active
    bit trip;   // expected to trip
    int lat;    // expected negedge index at which TRIPPED is first seen (0 = never)
  } flt_vec_t;

  typedef struct {
    bit            hiz;
    logic [CH-1:0] safe;
    logic [CH-1:0] pin;
    logic [CH-1:0] oein;
    logic [CH-1:0] exp_o;
    logic [CH-1:0] exp_oe;
  } out_vec_t;

  flt_vec_t ftab[9];
  out_vec_t otab[4];

  initial begin
    int first;
    int ints;

    ftab[0] = '{4, 1'b1, 10, 1'b1, 6};
    ftab[1] = '{4, 1'b1,  3, 1'b0, 0};
    ftab[2] = '{4, 1'b1,  4, 1'b1, 6};
    ftab[3] = '{0, 1'b1,  1, 1'b1, 3};
    ftab[4] = '{1, 1'b1,  1, 1'b1, 3};
    ftab[5] = '{0, 1'b0,  1, 1'b1, 3};
    ftab[6] = '{7, 1'b0,  6, 1'b0, 0};
    ftab[7] = '{7, 1'b0,  7, 1'b1, 9};
    ftab[8] = '{2, 1'b1,  1, 1'b0, 0};

    otab[0] = '{1'b0, 12'hA5A, 12'h0F0, 12'h00F, 12'hA5A, 12'h000};
    otab[1] = '{1'b1, 12'h5A5, 12'hFFF, 12'h000, 12'h5A5, 12'hFFF};
    otab[2] = '{1'b0, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    otab[3] = '{1'b1, 12'hFFF, 12'h123, 12'h456, 12'hFFF, 12'hFFF};

    // ---- reset state: pass-through while held in reset ----
    init_cfg(1, 1'b1, 1'b0, 1'b0, 12'hA5A);
    bus.cfg_en = 1'b1;
    fault      = 1'b1;
    pwm_in     = 12'h3C3;
    oe_n_in    = 12'h0F0;
    nclk(2);
    chk_st("rst_state", IDLE);
    chk("rst_sts", 32'(bus.fault_sts), 0);
    chk("rst_int", 32'(bus.fault_int), 0);
    chk("rst_o_pwm", 32'(o_pwm), 32'h3C3);
    chk("rst_oe_n", 32'(oe_n), 32'h0F0);

    // ---- filter / trip latency table ----
    foreach (ftab[k]) begin
      init_cfg(ftab[k].filt, ftab[k].pol, 1'b0, 1'b0, 12'hA5A);
      do_reset();
      bus.cfg_en = 1'b1;
      nclk(2);
      fault = ftab[k].pol;
      first = 0;
      ints  = 0;
      for (int j = 1; j <= 14; j++) begin
        @(negedge pclk);
        if (j == ftab[k].pulse) fault = ~ftab[k].pol;
        if (first == 0 && bus.state == 2'(TRIPPED)) first = j;
        if (bus.fault_int === 1'b1) ints++;
      end
      chk($sformatf("trip_lat[%0d]", k), 32'(first), 32'(ftab[k].lat));
      chk($sformatf("int_cnt[%0d]", k), 32'(ints), 32'(ftab[k].trip));
      $display("vec %0d: filt=%0d pol=%0d pulse=%0d -> trip edge %0d, fault_int x%0d",
               k, ftab[k].filt, ftab[k].pol, ftab[k].pulse, first, ints);
    end

    // ---- forced output table (controller held TRIPPED) ----
    init_cfg(1, 1'b1, 1'b0, 1'b0, 12'h000);
    do_reset();
    bus.cfg_en = 1'b1;
    nclk(1);
    fault = 1'b1;
    nclk(4);
    chk_st("force_setup", TRIPPED);
    foreach (otab[k]) begin
      bus.cfg_hiz      = otab[k].hiz;
      bus.cfg_safe_lvl = otab[k].safe;
      pwm_in           = otab[k].pin;
      oe_n_in          = otab[k].oein;
      #1;
      chk($sformatf("force_o[%0d]", k), 32'(o_pwm), 32'(otab[k].exp_o));
      chk($sformatf("force_oe[%0d]", k), 32'(oe_n), 32'(otab[k].exp_oe));
      $display("force %0d: hiz=%0d safe=%03h -> o_pwm=%03h oe_n=%03h", k, otab[k].hiz,
               otab[k].safe, o_pwm, oe_n);
      nclk(1);
    end

    // ---- manual recovery ----
    init_cfg(2, 1'b1, 1'b0, 1'b0, 12'hA5A);
    pwm_in  = 12'h123;
    oe_n_in = 12'h0F0;
    do_reset();
    bus.cfg_en = 1'b1;
    nclk(1);
    chk_st("man_armed", ARMED);
    fault = 1'b1;
    nclk(4);
    chk_st("man_trip", TRIPPED);
    chk("man_sts_set", 32'(bus.fault_sts), 1);
    bus.sw_clr = 1'b1; nclk(1); bus.sw_clr = 1'b0;
    nclk(1);
    chk_st("man_clr_ignored", TRIPPED);
    fault = 1'b0;
    nclk(3);
    chk_st("man_no_auto", TRIPPED);
    bus.sw_clr = 1'b1; nclk(1); bus.sw_clr = 1'b0;
    chk_st("man_recover", RECOVER);
    chk("man_rec_o_pwm", 32'(o_pwm), 32'hA5A);
    chk("man_rec_oe_n", 32'(oe_n), 32'h000);
    chk("man_rec_sts", 32'(bus.fault_sts), 1);
    prd_end = 1'b1; nclk(1); prd_end = 1'b0;
    chk_st("man_rearmed", ARMED);
    chk("man_pass_o_pwm", 32'(o_pwm), 32'h123);
    chk("man_pass_oe_n", 32'(oe_n), 32'h0F0);
    nclk(2);
    chk("man_sts_sticky", 32'(bus.fault_sts), 1);
    bus.sw_clr = 1'b1; nclk(1); bus.sw_clr = 1'b0;
    chk("man_sts_cleared", 32'(bus.fault_sts), 0);
    // sw_clr coincident with a trip: status must stay set
    fault = 1'b1;
    nclk(3);
    bus.sw_clr = 1'b1; nclk(1); bus.sw_clr = 1'b0;
    chk_st("man_trip2", TRIPPED);
    chk("man_set_wins", 32'(bus.fault_sts), 1);
    $display("seq manual recovery done");

    // ---- auto recovery with re-trip ----
    init_cfg(3, 1'b1, 1'b1, 1'b0, 12'h0F0);
    do_reset();
    bus.cfg_en = 1'b1;
    nclk(1);
    fault = 1'b1;
    nclk(4);
    chk_st("auto_pre_trip", ARMED);
    nclk(1);
    chk_st("auto_trip", TRIPPED);
    chk("auto_int1", 32'(bus.fault_int), 1);
    nclk(1);
    chk("auto_int1_end", 32'(bus.fault_int), 0);
    fault = 1'b0;
    nclk(2);
    chk_st("auto_still_trip", TRIPPED);
    nclk(1);
    chk_st("auto_recover", RECOVER);
    fault = 1'b1;
    nclk(4);
    chk_st("auto_rec_wait", RECOVER);
    nclk(1);
    chk_st("auto_retrip", TRIPPED);
    chk("auto_int2", 32'(bus.fault_int), 1);
    fault = 1'b0;
    nclk(3);
    chk_st("auto_recover2", RECOVER);
    fault = 1'b1;
    nclk(4);
    prd_end = 1'b1; nclk(1); prd_end = 1'b0;
    chk_st("auto_tie_trip", TRIPPED);
    chk("auto_int3", 32'(bus.fault_int), 1);
    $display("seq auto recovery done");

    // ---- polarity, Hi-Z, disable and async reset mid-trip ----
    init_cfg(2, 1'b0, 1'b0, 1'b1, 12'h555);
    fault   = 1'b0;  // active-low pin already asserted
    pwm_in  = 12'hABC;
    oe_n_in = 12'h00F;
    do_reset();
    nclk(3);
    chk_st("pol_idle", IDLE);
    chk("pol_idle_o_pwm", 32'(o_pwm), 32'hABC);
    bus.cfg_en = 1'b1;
    nclk(2);
    chk_st("pol_armed", ARMED);
    nclk(1);
    chk_st("pol_trip", TRIPPED);
    chk("pol_hiz_oe_n", 32'(oe_n), 32'hFFF);
    chk("pol_safe_o_pwm", 32'(o_pwm), 32'h555);
    bus.cfg_en = 1'b0;
    nclk(1);
    chk_st("dis_idle", IDLE);
    chk("dis_sts", 32'(bus.fault_sts), 0);
    chk("dis_o_pwm", 32'(o_pwm), 32'hABC);
    chk("dis_oe_n", 32'(oe_n), 32'h00F);
    bus.cfg_en = 1'b1;
    nclk(3);
    chk_st("rst_retrip", TRIPPED);
    chk("rst_retrip_int", 32'(bus.fault_int), 1);
    #2 presetn = 1'b0;
    #1;
    chk_st("async_rst_state", IDLE);
    chk("async_rst_int", 32'(bus.fault_int), 0);
    chk("async_rst_o_pwm", 32'(o_pwm), 32'hABC);
    chk("async_rst_oe_n", 32'(oe_n), 32'h00F);
    nclk(1);
    presetn = 1'b1;
    $display("seq polarity/disable/reset done");

    // ---- randomized run against the reference model ----
    for (int b = 0; b < 8; b++) begin
      bit lvl;
      int trips;
      init_cfg($urandom_range(0, 6), 1'(($urandom) & 1), 1'(($urandom) & 1),
               1'(($urandom) & 1), 12'($urandom));
      presetn = 1'b0;
      m_reset();
      nclk(2);
      presetn = 1'b1;
      lvl   = 1'b0;
      trips = 0;
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 7) == 0) lvl = ~lvl;
        fault      = lvl ? bus.cfg_pol : ~bus.cfg_pol;
        bus.cfg_en = ($urandom_range(0, 63) != 0);
        bus.sw_clr = ($urandom_range(0, 9) == 0);
        prd_end    = ($urandom_range(0, 5) == 0);
        pwm_in     = 12'($urandom);
        oe_n_in    = 12'($urandom);
        @(posedge pclk);
        m_step();
        @(negedge pclk);
        if (m_int) trips++;
        chk("rnd_state", 32'(bus.state), 32'(m_state));
        chk("rnd_int", 32'(bus.fault_int), 32'(m_int));
        chk("rnd_sts", 32'(bus.fault_sts), 32'(m_sts));
        chk("rnd_o_pwm", 32'(o_pwm), (m_state >= 2) ? 32'(bus.cfg_safe_lvl) : 32'(pwm_in));
        chk("rnd_oe_n", 32'(oe_n),
            (m_state >= 2) ? (bus.cfg_hiz ? 32'hFFF : 32'h000) : 32'(oe_n_in));
      end
      $display("burst %0d: filt=%0d pol=%0d auto=%0d hiz=%0d trips=%0d", b, bus.cfg_filt,
               bus.cfg_pol, bus.cfg_auto, bus.cfg_hiz, trips);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
